alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits; ALU operation type is alu_op_e from package types.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream presents an instruction.
REQ-005 in_ready  output  1  block accepts an instruction this cycle.
REQ-006 in_instr  input  32  RV32I instruction word.
REQ-007 in_rs1_data  input  32  rs1 register value.
REQ-008 in_rs2_data  input  32  rs2 register value.
REQ-009 out_valid  output  1  result entry available.
REQ-010 out_ready  input  1  downstream consumes the entry.
REQ-011 out_result  output  32  ALU result.
REQ-012 out_rd  output  5  destination register, in_instr[11:7].
REQ-013 out_zero  output  1  out_result == 0.
REQ-014 out_illegal  output  1  instruction not OP/OP-IMM, or bad funct7.

Function
REQ-015 Transfer in on clk edge with in_valid && in_ready; out on clk edge with out_valid && out_ready.
REQ-016 Decode: opcode 7'b0110011 (OP) -> operand b = rs2_data; 7'b0010011 (OP-IMM) -> b = sign-extended instr[31:20].
REQ-017 funct3 map: 000 ADD (SUB if OP and funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7=0100000), 110 OR, 111 AND.
REQ-018 OP-IMM funct3 000 never yields SUB; OP-IMM shifts use shamt instr[24:20].
REQ-019 Illegal: any other opcode; OP with funct7 not 0000000/0100000; 0100000 on OP with funct3 not 000/101; SLLI with funct7 != 0000000; SRLI/SRAI with funct7 not 0000000/0100000.
REQ-020 Illegal entries: out_illegal=1, out_result=0, out_zero=1, out_rd still instr[11:7].
REQ-021 rd == 0: out_result forced 0, out_zero=1 (x0 write discarded semantics).
REQ-022 Arithmetic via instantiated alu (a = rs1_data); SLT signed, SLTU unsigned, shifts use b[4:0], add/sub wrap mod 2^32.
REQ-023 Computed entry written into 2-entry FIFO output buffer; out_* driven from head entry, registered.
REQ-024 Latency: entry accepted at edge N appears with out_valid=1 after edge N when buffer was empty.
REQ-025 in_ready = (count < 2), derived from registered count only; no combinational path from out_ready to in_ready.
REQ-026 count 1 with simultaneous push and pop: count stays 1, new entry becomes head next cycle.
REQ-027 count 2: in_ready=0; pop frees a slot, in_ready=1 next cycle.
REQ-028 count 0: out_valid=0; pop ignored; order strictly FIFO.
REQ-029 out_* stable while out_valid && !out_ready.

Reset
REQ-030 rst_n low: count=0, out_valid=0, out_result=0, out_rd=0, out_zero=0, out_illegal=0, in_ready=0, asynchronously.
REQ-031 First edge after rst_n rises: in_ready=1.
REQ-032 Reset mid-operation discards all buffered entries; no partial entry emerges after release.

Verification
REQ-033 instr 0x002081B3 (add x3,x1,x2), rs1=25, rs2=10, out_ready=1 -> next cycle out_valid=1, result 35, rd 3, zero 0, illegal 0.
REQ-034 instr 0x402082B3 (sub x5,x1,x2), rs1=rs2=7 -> result 0, zero 1, rd 5.
REQ-035 instr 0x4040D313 (srai x6,x1,4), rs1=0x80000000 -> result 0xF8000000, rd 6.
REQ-036 out_ready=0, three back-to-back valid instructions -> first two accepted, in_ready=0 at third; out_ready=1 -> results emerge in issue order, third accepted one cycle after first pop.
REQ-037 instr 0x0000006F (jal) -> out_illegal 1, result 0, zero 1.
REQ-038 Two entries buffered, rst_n pulsed low mid-cycle -> out_valid 0 immediately, in_ready 1 first edge after release, no stale output.

Source files
------------

// File: rtl/alu_exec.sv
`default_nettype none

// ============================================================================
//  types
//  ALU operation encoding shared by the decoder and the arithmetic unit.
//  Revision: 1.0
// ============================================================================
package types;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

// ============================================================================
//  alu
//  Purely combinational 32-bit integer ALU.
//  Ports: op     - operation select (types::alu_op_e)
//         a, b   - operands; shifts use b[4:0] as the shift amount
//         result - operation result, add/sub wrap modulo 2^32
//  Revision: 1.0
// ============================================================================
module alu (
  input  types::alu_op_e op,
  input  logic [31:0]    a,
  input  logic [31:0]    b,
  output logic [31:0]    result
);
  import types::*;

  logic [4:0] w_shamt;
  assign w_shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << w_shamt;
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> w_shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end
endmodule

// ============================================================================
//  alu_exec
//  RV32I OP / OP-IMM execute stage: decodes the instruction, computes the
//  result through an alu instance and queues it in a 2-entry output FIFO.
//  Ports: clk, rst_n              - clock, async active-low reset
//         in_valid/in_ready       - upstream handshake
//         in_instr, in_rs1_data,
//         in_rs2_data             - instruction word and register operands
//         out_valid/out_ready     - downstream handshake
//         out_result, out_rd,
//         out_zero, out_illegal   - head entry of the output FIFO
//  Revision: 1.0
// ============================================================================
module alu_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_zero,
  output logic        out_illegal
);
  import types::*;

  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] C_F7_BASE    = 7'b0000000;
  localparam logic [6:0] C_F7_ALT     = 7'b0100000;
  localparam int         C_ENTRY_W    = 39;  // {illegal, zero, rd, result}

  // ---------------------------------------------------------------- decode
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic        w_is_op;
  logic        w_is_imm;
  logic        w_f7_alt;
  logic [31:0] w_imm;
  logic [31:0] w_b;
  alu_op_e     w_op;
  logic        w_illegal;
  logic [31:0] w_alu_result;
  logic [31:0] w_result;
  logic        w_zero;
  logic        w_unused_rs1_field;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_is_op  = (w_opcode == C_OPC_OP);
  assign w_is_imm = (w_opcode == C_OPC_OP_IMM);
  assign w_f7_alt = (w_funct7 == C_F7_ALT);
  assign w_imm    = {{20{in_instr[31]}}, in_instr[31:20]};
  // OP-IMM shifts pick up shamt from instr[24:20] via w_imm[4:0].
  assign w_b      = w_is_op ? in_rs2_data : w_imm;

  // The rs1 index field is resolved upstream; only its data is used here.
  assign w_unused_rs1_field = ^in_instr[19:15];

  always_comb begin
    w_op      = ALU_ADD;
    w_illegal = 1'b0;

    case (w_funct3)
      3'b000:  w_op = (w_is_op && w_f7_alt) ? ALU_SUB : ALU_ADD;
      3'b001:  w_op = ALU_SLL;
      3'b010:  w_op = ALU_SLT;
      3'b011:  w_op = ALU_SLTU;
      3'b100:  w_op = ALU_XOR;
      3'b101:  w_op = w_f7_alt ? ALU_SRA : ALU_SRL;
      3'b110:  w_op = ALU_OR;
      default: w_op = ALU_AND;
    endcase

    if (w_is_op) begin
      if (w_funct7 != C_F7_BASE && !w_f7_alt)
        w_illegal = 1'b1;
      else if (w_f7_alt && w_funct3 != 3'b000 && w_funct3 != 3'b101)
        w_illegal = 1'b1;
    end else if (w_is_imm) begin
      // Only the shift forms constrain the upper immediate bits.
      if (w_funct3 == 3'b001 && w_funct7 != C_F7_BASE)
        w_illegal = 1'b1;
      else if (w_funct3 == 3'b101 && w_funct7 != C_F7_BASE && !w_f7_alt)
        w_illegal = 1'b1;
    end else begin
      w_illegal = 1'b1;
    end
  end

  alu u_alu (
    .op     (w_op),
    .a      (in_rs1_data),
    .b      (w_b),
    .result (w_alu_result)
  );

  // Illegal entries and writes to x0 both report a zero result.
  assign w_result = (w_illegal || (w_rd == 5'd0)) ? 32'd0 : w_alu_result;
  assign w_zero   = (w_result == 32'd0);

  // ----------------------------------------------------------- output FIFO
  // Slot 0 lives directly in the out_* registers; slot 1 is r_tail.
  logic [C_ENTRY_W-1:0] w_new_entry;
  logic [C_ENTRY_W-1:0] r_tail;
  logic [1:0]           r_count;
  logic [1:0]           w_count_next;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 w_push;
  logic                 w_pop;

  assign w_new_entry = {w_illegal, w_zero, w_rd, w_result};
  assign w_push      = in_valid && r_in_ready;
  assign w_pop       = r_out_valid && out_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_tail      <= '0;
      out_result  <= 32'd0;
      out_rd      <= 5'd0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      // Handshake flags are registered from the next count so that neither
      // depends combinationally on out_ready.
      r_in_ready  <= (w_count_next < 2'd2);
      r_out_valid <= (w_count_next != 2'd0);

      if (w_push && (r_count == 2'd0 || (r_count == 2'd1 && w_pop))) begin
        {out_illegal, out_zero, out_rd, out_result} <= w_new_entry;
      end else if (w_pop && r_count == 2'd2) begin
        {out_illegal, out_zero, out_rd, out_result} <= r_tail;
      end

      if (w_push && r_count == 2'd1 && !w_pop)
        r_tail <= w_new_entry;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
endmodule

`default_nettype wire
